// File: rtl/fb_scanout.sv
// ============================================================================
// fb_scanout: 640x480@60 VGA scanout of a 120x60 3-bit framebuffer, scaled and centred.
// Optional feature macro: FB_SCANOUT_BORDER_EN (white one-pixel ring around the image).
// Revision: 1.0
// ============================================================================
`default_nettype none

module fb_scanout #(
  parameter int FB_W       = 120,
  parameter int FB_H       = 60,
  parameter int SCALE_LOG2 = 2,
  parameter int X_OFF      = 80,
  parameter int Y_OFF      = 120
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  output logic [15:0] raddr,
  input  logic [2:0]  rdata,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        active,
  output logic        frame_start
);

  localparam int c_WIN_W = FB_W << SCALE_LOG2;
  localparam int c_WIN_H = FB_H << SCALE_LOG2;

  localparam logic [9:0] c_H_LAST = 10'd799;
  localparam logic [9:0] c_V_LAST = 10'd524;
  localparam logic [9:0] c_H_VIS  = 10'd640;
  localparam logic [9:0] c_V_VIS  = 10'd480;
  localparam logic [9:0] c_V_FS   = 10'd479;
  localparam logic [9:0] c_HS_B   = 10'd656;
  localparam logic [9:0] c_HS_E   = 10'd752;
  localparam logic [9:0] c_VS_B   = 10'd490;
  localparam logic [9:0] c_VS_E   = 10'd492;

  localparam logic [9:0]  c_X0   = 10'(X_OFF);
  localparam logic [9:0]  c_X1   = 10'(X_OFF + c_WIN_W);
  localparam logic [9:0]  c_Y0   = 10'(Y_OFF);
  localparam logic [9:0]  c_Y1   = 10'(Y_OFF + c_WIN_H);
  localparam logic [15:0] c_FB_W = 16'(FB_W);

  logic [9:0]  r_h, r_v;
  logic [15:0] r_raddr;
  logic        r_s1_win, r_s1_vis, r_s1_hs, r_s1_vs;
  logic [11:0] r_rgb;
  logic        r_active, r_hs, r_vs, r_fs;

  logic        w_in_win;
  logic [9:0]  w_dx, w_dy;
  logic [15:0] w_addr;

  assign w_in_win = (r_h >= c_X0) && (r_h < c_X1) && (r_v >= c_Y0) && (r_v < c_Y1);
  assign w_dx     = r_h - c_X0;
  assign w_dy     = r_v - c_Y0;
  // Only meaningful inside the window; the largest product stays below 2^16.
  assign w_addr   = 16'(w_dy >> SCALE_LOG2) * c_FB_W + 16'(w_dx >> SCALE_LOG2);

`ifdef FB_SCANOUT_BORDER_EN
  localparam logic [9:0] c_XB0 = 10'(X_OFF - 1);
  localparam logic [9:0] c_YB0 = 10'(Y_OFF - 1);

  logic r_s1_border;
  logic w_border;

  // Ring = extended rectangle minus the window itself.
  assign w_border = (r_h >= c_XB0) && (r_h <= c_X1) && (r_v >= c_YB0) && (r_v <= c_Y1) && !w_in_win;
`endif

  always_ff @(posedge clk) begin
    r_fs <= 1'b0;
    if (rst) begin
      r_h      <= '0;
      r_v      <= '0;
      r_raddr  <= '0;
      r_s1_win <= 1'b0;
      r_s1_vis <= 1'b0;
      r_s1_hs  <= 1'b1;
      r_s1_vs  <= 1'b1;
      r_rgb    <= '0;
      r_active <= 1'b0;
      r_hs     <= 1'b1;
      r_vs     <= 1'b1;
`ifdef FB_SCANOUT_BORDER_EN
      r_s1_border <= 1'b0;
`endif
    end else if (pix_en) begin
      if (r_h == c_H_LAST) begin
        r_h <= '0;
        r_v <= (r_v == c_V_LAST) ? 10'd0 : r_v + 10'd1;
      end else begin
        r_h <= r_h + 10'd1;
      end
      r_fs <= (r_h == c_H_LAST) && (r_v == c_V_FS);

      r_raddr  <= w_in_win ? w_addr : 16'd0;
      r_s1_win <= w_in_win;
      r_s1_vis <= (r_h < c_H_VIS) && (r_v < c_V_VIS);
      r_s1_hs  <= !((r_h >= c_HS_B) && (r_h < c_HS_E));
      r_s1_vs  <= !((r_v >= c_VS_B) && (r_v < c_VS_E));
`ifdef FB_SCANOUT_BORDER_EN
      r_s1_border <= w_border;
`endif

      // rdata is the combinational answer to r_raddr, so it belongs to stage 1's pixel.
      if (r_s1_win) begin
        r_rgb <= {{4{rdata[2]}}, {4{rdata[1]}}, {4{rdata[0]}}};
`ifdef FB_SCANOUT_BORDER_EN
      end else if (r_s1_border) begin
        r_rgb <= 12'hFFF;
`endif
      end else begin
        r_rgb <= 12'h000;
      end
`ifdef FB_SCANOUT_BORDER_EN
      r_active <= r_s1_vis || r_s1_border;
`else
      r_active <= r_s1_vis;
`endif
      r_hs <= r_s1_hs;
      r_vs <= r_s1_vs;
    end
  end

  assign raddr       = r_raddr;
  assign hsync       = r_hs;
  assign vsync       = r_vs;
  assign vga_r       = r_rgb[11:8];
  assign vga_g       = r_rgb[7:4];
  assign vga_b       = r_rgb[3:0];
  assign active      = r_active;
  assign frame_start = r_fs;

endmodule

`default_nettype wire
